// File: rtl/mem_bus_router.sv
// Single-master address router: decodes mem_addr onto one of NUM_SLAVES ports,
// completes unmapped and timed-out accesses itself with ERR_DATA and sticky flags.

module mem_bus_router_match #(
  parameter logic [31:0] BASE = 32'h0,
  parameter logic [31:0] MASK = 32'h0
) (
  input  logic [31:0] addr,
  output logic        hit
);
  assign hit = (addr & MASK) == (BASE & MASK);
endmodule

module mem_bus_router #(
  parameter int                         NUM_SLAVES = 6,
  parameter logic [32*NUM_SLAVES-1:0]   SLAVE_BASE = {32'h5000, 32'h4000, 32'h3000,
                                                      32'h2000, 32'h1000, 32'h0000},
  parameter logic [32*NUM_SLAVES-1:0]   SLAVE_MASK = {NUM_SLAVES{32'h0000_F000}},
  parameter int                         TIMEOUT    = 255,
  parameter logic [31:0]                ERR_DATA   = 32'hDEAD_BEEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mem_valid,
  input  logic [31:0]                  mem_addr,
  input  logic [3:0]                   mem_wstrb,
  output logic                         mem_ready,
  output logic [31:0]                  mem_rdata,
  output logic [NUM_SLAVES-1:0]        s_cs,
  input  logic [NUM_SLAVES-1:0]        s_ready,
  input  logic [32*NUM_SLAVES-1:0]     s_rdata,
  input  logic                         err_clr,
  output logic                         err_unmapped,
  output logic                         err_timeout,
  output logic [31:0]                  err_addr
);
  localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, ERROR, DONE} state_t;

  state_t                state, state_d;
  logic [SW-1:0]         sel, hit_idx;
  logic [CW-1:0]         cnt;
  logic [NUM_SLAVES-1:0] match;
  logic                  any_hit, tmo_hit, unm_hit;
  logic                  wstrb_unused;

  // Strobes travel to the slaves on their own wiring; the router only routes.
  assign wstrb_unused = |mem_wstrb;

  for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_match
    mem_bus_router_match #(
      .BASE(SLAVE_BASE[32*i +: 32]),
      .MASK(SLAVE_MASK[32*i +: 32])
    ) u_match (
      .addr(mem_addr),
      .hit (match[i])
    );
  end

  // Scan high to low so the lowest matching index ends up selected.
  always_comb begin
    any_hit = |match;
    hit_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--)
      if (match[i]) hit_idx = SW'(i);
  end

  always_comb begin
    state_d   = state;
    mem_ready = 1'b0;
    mem_rdata = '0;
    s_cs      = '0;
    tmo_hit   = 1'b0;
    unm_hit   = 1'b0;
    case (state)
      IDLE:   if (mem_valid) state_d = any_hit ? ACTIVE : ERROR;
      ACTIVE: begin
        s_cs[sel] = 1'b1;
        if (s_ready[sel]) begin
          mem_ready = 1'b1;
          mem_rdata = s_rdata[32*sel +: 32];
          state_d   = DONE;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          mem_ready = 1'b1;
          mem_rdata = ERR_DATA;
          tmo_hit   = 1'b1;
          state_d   = DONE;
        end
      end
      ERROR: begin
        mem_ready = 1'b1;
        mem_rdata = ERR_DATA;
        unm_hit   = 1'b1;
        state_d   = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      sel          <= '0;
      cnt          <= '0;
      err_unmapped <= 1'b0;
      err_timeout  <= 1'b0;
      err_addr     <= '0;
    end else begin
      state <= state_d;
      if (state == IDLE && mem_valid && any_hit) begin
        sel <= hit_idx;
        cnt <= '0;
      end else if (state == ACTIVE && state_d == ACTIVE) begin
        cnt <= cnt + 1'b1;
      end
      // A new error outranks a simultaneous clear.
      err_unmapped <= unm_hit | (err_unmapped & ~err_clr);
      err_timeout  <= tmo_hit | (err_timeout & ~err_clr);
      if (unm_hit || tmo_hit) err_addr <= mem_addr;
    end
  end
endmodule
